// File: rtl/dot_product_engine.sv
// Dot-product sequencer: streams len element pairs from two 1-cycle-latency RAMs,
// accumulates the signed products, and publishes result/ovf on the DONE cycle.
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ACC_WIDTH-1:0]  result_o,
  output logic                  ovf_o,
  output logic [1:0]            state_o
);

  // Handshake: start_i is accepted only in IDLE or DONE (no queuing while busy);
  // done_o is a single-cycle pulse, and result_o/ovf_o are valid from the next cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO_LEN = '0;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH:0]             len_q, len_d, cnt_q, cnt_d, len_sat;
  logic                            acc_en_q;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d, result_q, result_d;
  logic signed [ACC_WIDTH-1:0]     prod_ext, sum;
  logic signed [2*DATA_WIDTH-1:0]  a_ext, b_ext, prod;
  logic                            acc_ovf_q, acc_ovf_d, ovf_q, ovf_d;
  logic                            add_ovf, accept, last;

  assign len_sat = (len_i > MAX_LEN) ? MAX_LEN : len_i;

  // Operands are sign-extended first so the multiply is full 2*DATA_WIDTH signed.
  assign a_ext    = {{DATA_WIDTH{a_data_i[DATA_WIDTH-1]}}, a_data_i};
  assign b_ext    = {{DATA_WIDTH{b_data_i[DATA_WIDTH-1]}}, b_data_i};
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_WIDTH'(prod);
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (cnt_q == (len_q - ONE));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = '0;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    result_d  = result_q;
    ovf_d     = ovf_q;

    // Data returned for the previous cycle's read is folded in here.
    if (acc_en_q) begin
      acc_d = sum;
      if (add_ovf) acc_ovf_d = 1'b1;
    end

    case (state_q)
      IDLE:  state_d = IDLE;
      FETCH: begin
        if (last) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        result_d = acc_q;
        ovf_d    = acc_ovf_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      len_d     = len_sat;
      acc_d     = '0;
      acc_ovf_d = 1'b0;
      state_d   = (len_sat == ZERO_LEN) ? DONE : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_en_q  <= rd_en_o;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd_en_o   = (state_q == FETCH);
  assign rd_addr_o = (state_q == FETCH) ? cnt_q[ADDR_WIDTH-1:0] : '0;
  assign busy_o    = (state_q == FETCH) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign result_o  = result_q;
  assign ovf_o     = ovf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: default-width instance plus a 16-bit accumulator
// instance run in lockstep, checked against an integer reference model.
module tb_dot_product_engine;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;

  logic          rd_en, busy, done, ovf;
  logic [AW-1:0] rd_addr;
  logic [18:0]   result;
  logic [1:0]    st;
  logic          rd_en16, busy16, done16, ovf16;
  logic [AW-1:0] rd_addr16;
  logic [15:0]   result16;
  logic [1:0]    st16;

  logic signed [DW-1:0] mem_a [8];
  logic signed [DW-1:0] mem_b [8];
  logic [18:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  dot_product_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .a_data_i(a_data), .b_data_i(b_data),
    .busy_o(busy), .done_o(done), .result_o(result), .ovf_o(ovf), .state_o(st)
  );

  dot_product_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len),
    .rd_en_o(rd_en16), .rd_addr_o(rd_addr16), .a_data_i(a_data), .b_data_i(b_data),
    .busy_o(busy16), .done_o(done16), .result_o(result16), .ovf_o(ovf16), .state_o(st16)
  );

  // Clock / reset block and the synchronous-read operand memories.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  // Reference: plain integer sum of products, wrapped into a w-bit signed range.
  function automatic void model(input int l, input int w, output longint s, output bit o);
    longint hi, lo, span;
    int n;
    span = longint'(1) << w;
    hi   = (span >> 1) - 1;
    lo   = -(span >> 1);
    n    = (l > 8) ? 8 : l;
    s    = 0;
    o    = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + longint'(mem_a[i]) * longint'(mem_b[i]);
      if (s > hi) begin s = s - span; o = 1'b1; end
      else if (s < lo) begin s = s + span; o = 1'b1; end
    end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'($urandom_range(0, 255));
      mem_b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Driver: one run with start held for one cycle, checking the whole timeline.
  task automatic run_vec(input int l, input string name);
    longint s19, s16;
    bit o19, o16;
    int n, cyc, seen, exp_done;
    logic [18:0] exp_r;
    model(l, 19, s19, o19);
    model(l, 16, s16, o16);
    exp_q.push_back(19'(s19));
    n = (l > 8) ? 8 : l;
    exp_done = n + 2;
    if (n == 0) exp_done = 1;
    @(negedge clk);
    start = 1'b1;
    len   = 4'(l);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 0;
    while (cyc <= n + 6) begin
      checks++;
      if (rd_en !== (cyc <= n) || busy !== (n > 0 && cyc <= n + 1) ||
          (rd_en && rd_addr !== 3'(cyc - 1))) begin
        failures++;
        $display("FAIL %s fetch c%0d: got rd_en=%b busy=%b addr=%0d expected rd_en=%b addr=%0d",
                 name, cyc, rd_en, busy, rd_addr, (cyc <= n), cyc - 1);
      end
      if (done) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (seen != exp_done) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, seen, exp_done);
    end
    @(negedge clk);
    exp_r = exp_q.pop_front();
    checks++;
    if (result !== exp_r || ovf !== o19 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s result: got %0d ovf=%b done=%b expected %0d ovf=%b",
               name, $signed(result), ovf, done, $signed(exp_r), o19);
    end
    checks++;
    if (result16 !== 16'(s16) || ovf16 !== o16) begin
      failures++;
      $display("FAIL %s result16: got %0d ovf=%b expected %0d ovf=%b",
               name, $signed(result16), ovf16, s16, o16);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_en, busy, done, ovf, rd_addr, result, rd_en16, done16, result16, ovf16} !== '0) begin
      failures++;
      $display("FAIL reset_value: got rd_en=%b busy=%b done=%b result=%0d expected all 0",
               rd_en, busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rd_en, busy, done, ovf, rd_addr, result} !== '0) begin
        failures++;
        $display("FAIL idle_quiet c%0d: got rd_en=%b busy=%b done=%b result=%0d expected all 0",
                 i, rd_en, busy, done, result);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    run_vec(4, "basic");
    checks++;
    if (result !== 19'd70 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_70: got %0d ovf=%b expected 70 ovf=0", result, ovf);
    end
  endtask

  task automatic test_negative_full();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = -8'sd128;
      mem_b[i] = -8'sd128;
    end
    run_vec(8, "neg_full");
    checks++;
    if (result !== 19'd131072 || ovf !== 1'b0 || result16 !== 16'd0 || ovf16 !== 1'b1) begin
      failures++;
      $display("FAIL neg_full_wrap: got %0d/%b r16=%0d/%b expected 131072/0 r16=0/1",
               result, ovf, result16, ovf16);
    end
  endtask

  task automatic test_length_edges();
    run_vec(0, "len0");
    checks++;
    if (result !== 19'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL len0_zero: got %0d ovf=%b expected 0 ovf=0", result, ovf);
    end
    fill_random();
    run_vec(15, "len15_sat");
    run_vec(9, "len9_sat");
  endtask

  task automatic test_back_to_back();
    logic [18:0] neg70;
    neg70 = -19'sd70;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    @(negedge clk);
    len = 4'd4;
    for (int c = 0; c <= 13; c++) begin
      if (c >= 1) begin
        checks++;
        if (done !== (c == 6 || c == 12) ||
            rd_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
          failures++;
          $display("FAIL b2b_timeline c%0d: got done=%b rd_en=%b", c, done, rd_en);
        end
      end
      if (c == 7) begin
        checks++;
        if (busy !== 1'b1 || rd_addr !== 3'd0) begin
          failures++;
          $display("FAIL b2b_restart: got busy=%b addr=%0d expected busy=1 addr=0", busy, rd_addr);
        end
      end
      if (c >= 7 && c <= 12) begin
        checks++;
        if (result !== 19'd70) begin
          failures++;
          $display("FAIL b2b_first c%0d: got %0d expected 70", c, $signed(result));
        end
      end
      if (c == 13) begin
        checks++;
        if (result !== neg70 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL b2b_second: got %0d ovf=%b expected -70 ovf=0", $signed(result), ovf);
        end
      end
      if (c == 5) begin
        for (int i = 0; i < 8; i++) mem_b[i] = 8'(-(i + 5));
      end
      start = (c == 0 || c == 2 || c == 5 || c == 6);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'(i + 2);
      mem_b[i] = 8'(3);
    end
    run_vec(4, "pre_reset");
    @(negedge clk);
    start = 1'b1;
    len   = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_en, busy, done, ovf, rd_addr, result, result16} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got rd_en=%b busy=%b done=%b result=%0d expected all 0",
               rd_en, busy, done, result);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_hold c%0d: got done=%b busy=%b expected 0", i, done, busy);
      end
    end
    rst = 1'b1;
    fill_random();
    run_vec(8, "post_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_vec(int'($urandom_range(0, 15)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_basic();
    test_negative_full();
    test_length_edges();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
